// File: rtl/mips_syscall_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_syscall_pkg
//  Description : Service codes, FSM state encoding and dispatch helpers
//                shared by the SYSCALL service unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_syscall_pkg;

    localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
    localparam logic [31:0] SVC_READ_INT   = 32'd5;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SVC_READ_CHAR  = 32'd12;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_PRINT = 3'd1;
    localparam state_t ST_READ  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;
    localparam state_t ST_HALT  = 3'd5;

    // Unknown codes fall through to DONE, where the error pulse is raised.
    function automatic state_t svc_dispatch(input logic [31:0] code);
        state_t st;
        case (code)
            SVC_PRINT_INT, SVC_PRINT_CHAR: st = ST_PRINT;
            SVC_READ_INT,  SVC_READ_CHAR:  st = ST_READ;
            SVC_EXIT:                      st = ST_HALT;
            default:                       st = ST_DONE;
        endcase
        return st;
    endfunction

    function automatic logic svc_known(input logic [31:0] code);
        return (code == SVC_PRINT_INT)  || (code == SVC_PRINT_CHAR) ||
               (code == SVC_READ_INT)   || (code == SVC_READ_CHAR)  ||
               (code == SVC_EXIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/syscall_timer.sv
`default_nettype none
// ============================================================================
//  Module      : syscall_timer
//  Description : Loadable down-counter with an expiry flag (count == 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module syscall_timer #(
    parameter int WIDTH      = 4,
    parameter int LOAD_VALUE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = WIDTH'(LOAD_VALUE);
        end else if (i_en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/syscall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : syscall_unit
//  Description : Multicycle SYSCALL service unit (console print/read, exit).
//                Optional read timeout enabled by MIPS_SYSCALL_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module syscall_unit
    import mips_syscall_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        iCLK,
    input  logic        iCLR,
    input  logic        iSyscall,
    input  logic [31:0] iRegV0,
    input  logic [31:0] iRegA0,
    output logic        oStall,
    output logic [31:0] oRegA0,
    output logic        oA0en,
    output logic [31:0] oOutData,
    output logic        oOutChar,
    output logic        oOutValid,
    input  logic        iOutReady,
    input  logic [31:0] iInData,
    input  logic        iInValid,
    output logic        oInReady,
    output logic        oDone,
    output logic        oError,
    output logic        oHalt
);

    localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES + 1);

    state_t      state_q, state_d;
    logic [31:0] v0_q, v0_d;
    logic [31:0] a0_q, a0_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;

    logic        w_accept;
    logic        w_timeout_hit;
    logic        w_read_entry;

    assign w_accept     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && iSyscall;
    assign w_read_entry = (state_d == ST_READ) && (state_q != ST_READ);

`ifdef MIPS_SYSCALL_TIMEOUT_EN
    logic w_tmr_expired;

    syscall_timer #(
        .WIDTH      (c_tmr_w),
        .LOAD_VALUE (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (iCLK),
        .rst       (iCLR),
        .i_load    (w_read_entry),
        .i_en      (state_q == ST_READ),
        .o_expired (w_tmr_expired)
    );

    assign w_timeout_hit = (state_q == ST_READ) && w_tmr_expired;
`else
    logic [c_tmr_w-1:0] unused_tmr;
    logic               unused_entry;

    assign unused_tmr    = c_tmr_w'(TIMEOUT_CYCLES);
    assign unused_entry  = w_read_entry;
    assign w_timeout_hit = 1'b0;
`endif

    // State register (all flops).
    always_ff @(posedge iCLK or posedge iCLR) begin
        if (iCLR) begin
            state_q   <= ST_IDLE;
            v0_q      <= '0;
            a0_q      <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            v0_q      <= v0_d;
            a0_q      <= a0_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d   = state_q;
        v0_d      = v0_q;
        a0_d      = a0_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (iSyscall) begin
                    state_d = svc_dispatch(iRegV0);
                    v0_d    = iRegV0;
                    a0_d    = iRegA0;
                    err_d   = ~svc_known(iRegV0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRINT: begin
                if (iOutReady) begin
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                // Input arriving in the timeout cycle takes priority.
                if (iInValid) begin
                    state_d   = ST_WRITE;
                    rd_data_d = (v0_q == SVC_READ_CHAR) ? {24'b0, iInData[7:0]} : iInData;
                end else if (w_timeout_hit) begin
                    state_d   = ST_WRITE;
                    rd_data_d = '0;
                    err_d     = 1'b1;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode; oStall uses the live request so the CPU freezes in the request cycle.
    always_comb begin
        oStall    = w_accept ||
                    (state_q == ST_PRINT) || (state_q == ST_READ) ||
                    (state_q == ST_WRITE) || (state_q == ST_HALT);
        oOutValid = (state_q == ST_PRINT);
        oOutChar  = (state_q == ST_PRINT) && (v0_q == SVC_PRINT_CHAR);
        oOutData  = '0;
        if (state_q == ST_PRINT) begin
            oOutData = (v0_q == SVC_PRINT_CHAR) ? {24'b0, a0_q[7:0]} : a0_q;
        end
        oInReady  = (state_q == ST_READ);
        oA0en     = (state_q == ST_WRITE);
        oRegA0    = (state_q == ST_WRITE) ? rd_data_q : '0;
        oDone     = (state_q == ST_DONE);
        oError    = (state_q == ST_DONE) && err_q;
        oHalt     = (state_q == ST_HALT);
    end

endmodule
`default_nettype wire

// File: tb/tb_syscall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_syscall_unit
//  Description : Self-checking bench for syscall_unit: table vectors,
//                randomized services against a transaction-level model,
//                and hand-written reset / exit sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_syscall_unit;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        iCLR;
    logic        iSyscall;
    logic [31:0] iRegV0, iRegA0;
    logic        oStall;
    logic [31:0] oRegA0;
    logic        oA0en;
    logic [31:0] oOutData;
    logic        oOutChar, oOutValid;
    logic        iOutReady;
    logic [31:0] iInData;
    logic        iInValid;
    logic        oInReady, oDone, oError, oHalt;

    int n_chk = 0;
    int n_err = 0;
    bit pend_done = 1'b0;
    bit pend_err  = 1'b0;

    always #5 clk = ~clk;

    syscall_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .iCLK(clk), .iCLR(iCLR), .iSyscall(iSyscall),
        .iRegV0(iRegV0), .iRegA0(iRegA0),
        .oStall(oStall), .oRegA0(oRegA0), .oA0en(oA0en),
        .oOutData(oOutData), .oOutChar(oOutChar), .oOutValid(oOutValid),
        .iOutReady(iOutReady), .iInData(iInData), .iInValid(iInValid),
        .oInReady(oInReady), .oDone(oDone), .oError(oError), .oHalt(oHalt)
    );

    typedef struct packed {
        logic        stall;
        logic        valid;
        logic        chr;
        logic [31:0] odata;
        logic        inrdy;
        logic        a0en;
        logic [31:0] ra0;
        logic        done;
        logic        err;
        logic        halt;
    } obs_t;

    typedef struct {
        logic [31:0] v0;
        logic [31:0] a0;
        int          dly;
        logic [31:0] ind;
        bit          b2b;
    } vec_t;

    function automatic bit tmo_en();
`ifdef MIPS_SYSCALL_TIMEOUT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.stall = oStall;   o.valid = oOutValid; o.chr  = oOutChar;
        o.odata = oOutData; o.inrdy = oInReady;  o.a0en = oA0en;
        o.ra0   = oRegA0;   o.done  = oDone;     o.err  = oError;
        o.halt  = oHalt;
        return o;
    endfunction

    task automatic check(input string nm, input obs_t exp);
        obs_t got;
        got = sample();
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Inputs for this cycle are already driven; check mid-cycle, then move to next cycle.
    task automatic cyc(input string nm, input obs_t exp);
        @(negedge clk);
        check(nm, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        obs_t e;
        iSyscall = 1'b0; iOutReady = 1'b0; iInValid = 1'b0;
        e = '0; e.done = pend_done; e.err = pend_err;
        cyc("done_or_idle", e);
        pend_done = 1'b0; pend_err = 1'b0;
    endtask

    // Drives one service and checks it against the rules; the trailing DONE
    // cycle is left pending so the next request may overlap it.
    task automatic run_svc(input logic [31:0] v0, input logic [31:0] a0,
                           input int dly, input logic [31:0] ind);
        obs_t        e;
        logic [31:0] pay;
        bit          is_print, is_read, is_char, to;
        int          nread;

        is_print = (v0 == 32'd1) || (v0 == 32'd11);
        is_read  = (v0 == 32'd5) || (v0 == 32'd12);
        is_char  = (v0 == 32'd11) || (v0 == 32'd12);

        iSyscall = 1'b1; iRegV0 = v0; iRegA0 = a0;
        iOutReady = 1'b0; iInValid = 1'b0;
        e = '0; e.stall = 1'b1; e.done = pend_done; e.err = pend_err;
        cyc("request", e);
        iSyscall = 1'b0; iRegV0 = $urandom; iRegA0 = $urandom;
        pend_done = 1'b0; pend_err = 1'b0;

        if (is_print) begin
            pay = is_char ? {24'b0, a0[7:0]} : a0;
            for (int k = 1; k <= dly + 1; k++) begin
                iOutReady = (k == dly + 1);
                iSyscall  = 1'($urandom_range(0, 1));
                e = '0; e.stall = 1'b1; e.valid = 1'b1; e.chr = is_char; e.odata = pay;
                cyc("print", e);
            end
            iOutReady = 1'b0; iSyscall = 1'b0;
            pend_done = 1'b1;
        end else if (is_read) begin
            to    = tmo_en() && (dly > TMO);
            nread = to ? TMO + 1 : dly + 1;
            for (int k = 1; k <= nread; k++) begin
                iInValid = (k == dly + 1);
                iInData  = (k == dly + 1) ? ind : $urandom;
                iSyscall = 1'($urandom_range(0, 1));
                e = '0; e.stall = 1'b1; e.inrdy = 1'b1;
                cyc("read_wait", e);
            end
            iInValid = 1'b0; iInData = $urandom; iSyscall = 1'b1;
            pay = to ? 32'd0 : (is_char ? {24'b0, ind[7:0]} : ind);
            e = '0; e.stall = 1'b1; e.a0en = 1'b1; e.ra0 = pay;
            cyc("read_write", e);
            iSyscall = 1'b0;
            pend_done = 1'b1; pend_err = to;
        end else if (v0 == 32'd10) begin
            for (int k = 1; k <= dly; k++) begin
                iSyscall = 1'($urandom_range(0, 1));
                iRegV0   = 32'd1;
                e = '0; e.stall = 1'b1; e.halt = 1'b1;
                cyc("halt", e);
            end
            iSyscall = 1'b0;
        end else begin
            pend_done = 1'b1; pend_err = 1'b1;
        end
    endtask

    task automatic reset_now(input string nm);
        obs_t z;
        z = '0;
        iSyscall = 1'b0; iOutReady = 1'b0; iInValid = 1'b0;
        iCLR = 1'b1;
        #1;
        check({nm, "_async"}, z);
        @(posedge clk);
        #1;
        iCLR = 1'b0;
        cyc({nm, "_idle"}, z);
        pend_done = 1'b0; pend_err = 1'b0;
    endtask

    vec_t tbl[12];

    initial begin
        obs_t        e;
        logic [31:0] code;
        int          pick;

        tbl[0]  = '{32'd1,  32'hFFFF_FFF6, 3,  32'h0,         1'b0};
        tbl[1]  = '{32'd12, 32'h0,         4,  32'h1234_5641, 1'b0};
        tbl[2]  = '{32'd99, 32'h5,         0,  32'h0,         1'b0};
        tbl[3]  = '{32'd11, 32'h1234_56C8, 0,  32'h0,         1'b0};
        tbl[4]  = '{32'd5,  32'h0,         0,  32'hDEAD_BEEF, 1'b0};
        tbl[5]  = '{32'd0,  32'h0,         0,  32'h0,         1'b0};
        tbl[6]  = '{32'h101,32'h7,         0,  32'h0,         1'b1};
        tbl[7]  = '{32'd5,  32'h0,         2,  32'h8000_0001, 1'b1};
        tbl[8]  = '{32'd11, 32'hABCD_EF7A, 1,  32'h0,         1'b1};
        tbl[9]  = '{32'd1,  32'h0,         0,  32'h0,         1'b0};
        tbl[10] = '{32'd5,  32'h0,         20, 32'h1111_2222, 1'b0};
        tbl[11] = '{32'd12, 32'h0,         TMO,32'h0000_33C5, 1'b0};

        iCLR = 1'b1; iSyscall = 1'b0; iRegV0 = '0; iRegA0 = '0;
        iOutReady = 1'b0; iInData = '0; iInValid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", '0);
        @(posedge clk);
        #1;
        iCLR = 1'b0;
        cyc("idle_after_reset", '0);

        foreach (tbl[i]) begin
            run_svc(tbl[i].v0, tbl[i].a0, tbl[i].dly, tbl[i].ind);
            if (!tbl[i].b2b) idle_cycle();
        end

        for (int t = 0; t < 60; t++) begin
            pick = $urandom_range(0, 4);
            case (pick)
                0: code = 32'd1;
                1: code = 32'd11;
                2: code = 32'd5;
                3: code = 32'd12;
                default: begin
                    code = $urandom;
                    if (code == 32'd10) code = 32'd99;
                end
            endcase
            run_svc(code, $urandom, $urandom_range(0, 11), $urandom);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

        // Reset pulse while waiting for console input.
        iSyscall = 1'b1; iRegV0 = 32'd5; iRegA0 = 32'h0;
        e = '0; e.stall = 1'b1;
        cyc("rst_req", e);
        iSyscall = 1'b0;
        e = '0; e.stall = 1'b1; e.inrdy = 1'b1;
        cyc("rst_read_wait", e);
        reset_now("mid_read_reset");

        // Exit: sticky through 100 cycles and further requests, cleared only by reset.
        run_svc(32'd10, 32'h0, 100, 32'h0);
        reset_now("halt_reset");
        run_svc(32'd1, 32'h0000_002A, 0, 32'h0);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/syscall_unit.md
# syscall_unit

Multicycle service unit for the SYSCALL instruction. When the control unit signals a syscall, it samples $v0 (service code) and $a0 (argument) from the register bank and stalls the control FSM. It then runs the service against a console output channel or input channel, or halts the core. For read services it writes the result back into $a0 through the register bank's dedicated $a0 write port.

## Interface
- TIMEOUT_CYCLES, 1000000: read-service timeout in clock cycles; used only with MIPS_SYSCALL_TIMEOUT_EN.
- iCLK  in  1  system clock; all state changes on the rising edge.
- iCLR  in  1  reset, asynchronous, active-high.
- iSyscall  in  1  one-cycle request from the control unit.
- iRegV0  in  32  current $v0 from the register bank.
- iRegA0  in  32  current $a0 from the register bank.
- oStall  out  1  holds the control FSM.
- oRegA0  out  32  write-back value for $a0.
- oA0en  out  1  $a0 write enable; one-cycle pulse.
- oOutData  out  32  console output payload.
- oOutChar  out  1  1 = character, 0 = signed integer.
- oOutValid  out  1  output request.
- iOutReady  in  1  console accepts the output.
- iInData  in  32  console input payload.
- iInValid  in  1  console input available.
- oInReady  out  1  unit waiting for input.
- oDone  out  1  one-cycle service-complete pulse.
- oError  out  1  one-cycle pulse for an unknown service code.
- oHalt  out  1  sticky exit flag.

## Operation
- Service codes, taken from iRegV0[31:0] compared in full:
  - 1 = print int
  - 11 = print char
  - 5 = read int
  - 12 = read char
  - 10 = exit
  - anything else = unknown
- FSM states are IDLE, PRINT, READ, WRITE, DONE and HALT.
- IDLE or DONE, iSyscall=1: latch iRegV0 and iRegA0, then dispatch on the next edge:
  - print codes go to PRINT
  - read codes go to READ
  - 10 goes to HALT
  - unknown codes go to DONE with oError=1 in that DONE cycle
- PRINT:
  - oOutValid=1 and oOutData are held stable until iOutReady=1, then go to DONE.
  - Int: oOutData = latched $a0.
  - Char: oOutData = {24'b0, a0[7:0]} and oOutChar=1.
- READ:
  - oInReady=1 until iInValid=1, then capture the value and go to WRITE.
  - Int: full 32 bits.
  - Char: {24'b0, iInData[7:0]}.
- WRITE: oA0en=1 and oRegA0 = captured value for exactly one cycle, then go to DONE.
- DONE: oDone=1 for one cycle. Without a new iSyscall, go to IDLE.
- HALT: oHalt=1 and oStall=1 permanently; only iCLR leaves this state.
- oStall = iSyscall in IDLE/DONE, OR state ∈ {PRINT, READ, WRITE, HALT}. This is a combinational term, so the control unit freezes in the request cycle. oStall=0 in DONE unless a new iSyscall arrives.
- iSyscall in PRINT/READ/WRITE/HALT is ignored.
- Output payload registers do not change while oOutValid=1 and iOutReady=0.
- iCLR at any point:
  - State goes to IDLE immediately and all outputs go to 0, including oHalt and the data buses.
  - Any in-flight handshake is abandoned without completion.

## Timing
- Reset values: every output is 0.
- Print, iOutReady tied high: request at cycle 0, oOutValid at cycle 1, oDone at cycle 2.
- Read, iInValid already high: request at cycle 0, oInReady at cycle 1, oA0en at cycle 2, oDone at cycle 3.
- $a0 is updated by the register bank at the edge that ends the WRITE cycle. oStall covers WRITE, so the CPU never reads a stale $a0.
- The error path completes in 2 cycles: oError and oDone are both in cycle 1.
- The earliest back-to-back request is the DONE cycle of the previous service.

## Configuration
- MIPS_SYSCALL_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in READ and clears on READ entry.
  - When it reaches TIMEOUT_CYCLES without iInValid, the captured value is forced to 0 and the FSM goes to WRITE, so $a0 is written with 0.
  - oError pulses in the following DONE cycle.
  - iInValid arriving in the timeout cycle wins over the timeout.
- MIPS_SYSCALL_TIMEOUT_EN undefined: no counter; READ waits indefinitely.

## Structure
- The shared package mips_syscall_pkg holds:
  - service code localparams: SVC_PRINT_INT=1, SVC_READ_INT=5, SVC_EXIT=10, SVC_PRINT_CHAR=11, SVC_READ_CHAR=12
  - the FSM state encoding
- One sub-module, syscall_timer: a loadable down-counter with an expiry flag. It is instantiated only under MIPS_SYSCALL_TIMEOUT_EN.

## Test plan
- Reset: pulse iCLR mid-READ with oInReady=1 → the next cycle is IDLE, every output is 0, and oStall=0.
- Print int: v0=1, a0=32'hFFFFFFF6, iOutReady held low for 3 cycles → oOutValid=1 with oOutData=32'hFFFFFFF6 stable throughout, oOutChar=0, then oDone one cycle after ready.
- Read char: v0=12, iInData=32'h12345641 arriving 5 cycles after the request → oA0en pulse with oRegA0=32'h00000041, oDone the next cycle, oStall low in DONE.
- Exit: v0=10 → oHalt=1 and oStall=1 are held for 100 cycles despite further iSyscall pulses; iCLR clears both.
- Unknown code: v0=99 → oError and oDone pulse together one cycle after the request, with no oOutValid, oInReady or oA0en.
- Timeout (macro on, TIMEOUT_CYCLES=8): v0=5 with no input → oA0en with oRegA0=0 after the timeout, then oError with oDone.
